// File: rtl/smalldiv_seq.sv
// smalldiv_seq: sequential unsigned divider by a small divisor that is chosen at run time.
// The divisor is sampled together with the dividend for each operation.
// Each RUN cycle is one radix-2^BITS_PER_CYCLE restoring step, so an operation takes
// DIVIDEND_WIDTH/BITS_PER_CYCLE RUN cycles. There is a valid/ready handshake on both sides.
// A divisor of zero finishes on the accepting edge: the quotient is all ones, the remainder
// is zero and div_by_zero is set.
// Optional feature macro: SMALLDIV_SEQ_POW2_BYPASS_EN. When it is defined, a divisor that is
// a nonzero power of two is resolved on the accepting edge with a shift and a mask.
module smalldiv_seq #(
    parameter int DIVIDEND_WIDTH = 18,
    parameter int DIVISOR_WIDTH  = 4,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DIVIDEND_WIDTH-1:0] dividend,
    input  logic [DIVISOR_WIDTH-1:0]  divisor,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DIVIDEND_WIDTH-1:0] quotient,
    output logic [DIVISOR_WIDTH-1:0]  remainder,
    output logic                      div_by_zero
);

    localparam int N     = DIVIDEND_WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    // The partial remainder is always below the divisor, so DIVISOR_WIDTH+BITS_PER_CYCLE
    // bits are enough to hold one shifted-in trial value without overflow.
    localparam int PW    = DIVISOR_WIDTH + BITS_PER_CYCLE;
    localparam int NDIG  = 1 << BITS_PER_CYCLE;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                    state_q;
    logic [CNT_W-1:0]          cnt_q;
    // Working register. Dividend bits leave from the top and quotient digits enter at the
    // bottom, so after N steps it holds the whole quotient.
    logic [DIVIDEND_WIDTH-1:0] dvd_q;
    logic [DIVISOR_WIDTH-1:0]  dvs_q;
    logic [DIVISOR_WIDTH-1:0]  prem_q;
    logic                      out_valid_q;
    logic [DIVIDEND_WIDTH-1:0] quotient_q;
    logic [DIVISOR_WIDTH-1:0]  remainder_q;
    logic                      dbz_q;

    logic                      in_ready_s;
    logic                      accept_s;
    logic [PW-1:0]             trial_s;
    logic [PW-1:0]             mult_s;
    logic [BITS_PER_CYCLE-1:0] digit_s;
    logic [DIVISOR_WIDTH-1:0]  sub_s;
    logic [DIVISOR_WIDTH-1:0]  prem_d;
    logic [DIVIDEND_WIDTH-1:0] dvd_d;

`ifdef SMALLDIV_SEQ_POW2_BYPASS_EN
    // True when d has exactly one bit set
    function automatic logic is_pow2_f(input logic [DIVISOR_WIDTH-1:0] d);
        return (d != {DIVISOR_WIDTH{1'b0}}) &&
               ((d & (d - DIVISOR_WIDTH'(1))) == {DIVISOR_WIDTH{1'b0}});
    endfunction

    // Shift right by log2(d); d is known to be a power of two
    function automatic logic [DIVIDEND_WIDTH-1:0] pow2_quot_f(
        input logic [DIVIDEND_WIDTH-1:0] a,
        input logic [DIVISOR_WIDTH-1:0]  d
    );
        logic [DIVIDEND_WIDTH-1:0] res;
        res = a;
        for (int i = 0; i < DIVISOR_WIDTH; i++) begin
            if (d[i]) begin
                res = a >> i;
            end else begin
                res = res;
            end
        end
        return res;
    endfunction
`endif

    // Handshake: take a new operand when idle, or when the finished result is being retired
    always_comb begin
        in_ready_s = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
        accept_s   = in_valid && in_ready_s;
    end

    // One restoring step: take the largest multiple of the divisor that fits the trial value
    always_comb begin
        trial_s = {prem_q, dvd_q[DIVIDEND_WIDTH-1 -: BITS_PER_CYCLE]};
        mult_s  = {PW{1'b0}};
        digit_s = {BITS_PER_CYCLE{1'b0}};
        sub_s   = {DIVISOR_WIDTH{1'b0}};
        for (int k = 1; k < NDIG; k++) begin
            mult_s = PW'(k) * {{BITS_PER_CYCLE{1'b0}}, dvs_q};
            if (mult_s <= trial_s) begin
                digit_s = BITS_PER_CYCLE'(k);
                sub_s   = mult_s[DIVISOR_WIDTH-1:0];
            end else begin
                digit_s = digit_s;
                sub_s   = sub_s;
            end
        end
        // The difference is below the divisor, so its low bits are the whole result
        prem_d = trial_s[DIVISOR_WIDTH-1:0] - sub_s;
        dvd_d  = {dvd_q[DIVIDEND_WIDTH-BITS_PER_CYCLE-1:0], digit_s};
    end

    // Control FSM: operand capture, iteration, and registered results
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            dvd_q       <= {DIVIDEND_WIDTH{1'b0}};
            dvs_q       <= {DIVISOR_WIDTH{1'b0}};
            prem_q      <= {DIVISOR_WIDTH{1'b0}};
            out_valid_q <= 1'b0;
            quotient_q  <= {DIVIDEND_WIDTH{1'b0}};
            remainder_q <= {DIVISOR_WIDTH{1'b0}};
            dbz_q       <= 1'b0;
        end else if (accept_s) begin
            // Accepting in DONE retires the held result on the same edge
            if (divisor == {DIVISOR_WIDTH{1'b0}}) begin
                state_q     <= S_DONE;
                cnt_q       <= {CNT_W{1'b0}};
                out_valid_q <= 1'b1;
                quotient_q  <= {DIVIDEND_WIDTH{1'b1}};
                remainder_q <= {DIVISOR_WIDTH{1'b0}};
                dbz_q       <= 1'b1;
            end
`ifdef SMALLDIV_SEQ_POW2_BYPASS_EN
            else if (is_pow2_f(divisor)) begin
                state_q     <= S_DONE;
                cnt_q       <= {CNT_W{1'b0}};
                out_valid_q <= 1'b1;
                quotient_q  <= pow2_quot_f(dividend, divisor);
                remainder_q <= dividend[DIVISOR_WIDTH-1:0] & (divisor - DIVISOR_WIDTH'(1));
                dbz_q       <= 1'b0;
            end
`endif
            else begin
                state_q     <= S_RUN;
                cnt_q       <= CNT_W'(N - 1);
                dvd_q       <= dividend;
                dvs_q       <= divisor;
                prem_q      <= {DIVISOR_WIDTH{1'b0}};
                out_valid_q <= 1'b0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    out_valid_q <= 1'b0;
                end
                S_RUN: begin
                    dvd_q  <= dvd_d;
                    prem_q <= prem_d;
                    if (cnt_q == {CNT_W{1'b0}}) begin
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                        quotient_q  <= dvd_d;
                        remainder_q <= prem_d;
                        dbz_q       <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    // Result stays on the outputs until the consumer takes it
                    if (out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                    end else begin
                        out_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_s;
    assign out_valid   = out_valid_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_smalldiv_seq.sv
// Testbench for smalldiv_seq. It uses a scoreboard of expected results and tests the
// default configuration plus instances with BITS_PER_CYCLE = 2 and 3.
module tb_smalldiv_seq;

    localparam int DW = 18;
    localparam int DSW = 4;
    localparam int N = 18;

    logic           clock = 1'b0;
    logic           reset;
    logic           in_valid;
    logic           out_ready;
    logic [DW-1:0]  dividend;
    logic [DSW-1:0] divisor;

    logic           in_ready, out_valid, div_by_zero;
    logic [DW-1:0]  quotient;
    logic [DSW-1:0] remainder;
    logic           in_ready2, out_valid2, dbz2;
    logic [DW-1:0]  quotient2;
    logic [DSW-1:0] remainder2;
    logic           in_ready3, out_valid3, dbz3;
    logic [DW-1:0]  quotient3;
    logic [DSW-1:0] remainder3;

    typedef struct {
        logic [DW-1:0]  q;
        logic [DSW-1:0] r;
        logic           z;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clock = ~clock;

    smalldiv_seq #(.DIVIDEND_WIDTH(DW), .DIVISOR_WIDTH(DSW), .BITS_PER_CYCLE(1)) u_dut1 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor), .out_valid(out_valid), .out_ready(out_ready),
        .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero));

    smalldiv_seq #(.DIVIDEND_WIDTH(DW), .DIVISOR_WIDTH(DSW), .BITS_PER_CYCLE(2)) u_dut2 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
        .dividend(dividend), .divisor(divisor), .out_valid(out_valid2), .out_ready(out_ready),
        .quotient(quotient2), .remainder(remainder2), .div_by_zero(dbz2));

    smalldiv_seq #(.DIVIDEND_WIDTH(DW), .DIVISOR_WIDTH(DSW), .BITS_PER_CYCLE(3)) u_dut3 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready3),
        .dividend(dividend), .divisor(divisor), .out_valid(out_valid3), .out_ready(out_ready),
        .quotient(quotient3), .remainder(remainder3), .div_by_zero(dbz3));

    // Reference model: plain / and %, with the divide-by-zero convention
    task automatic push_exp(input logic [DW-1:0] a, input logic [DSW-1:0] b);
        exp_t e;
        if (b == 4'd0) begin
            e.q = {DW{1'b1}};
            e.r = 4'd0;
            e.z = 1'b1;
        end else begin
            e.q = a / DW'(b);
            e.r = DSW'(a % DW'(b));
            e.z = 1'b0;
        end
        sb.push_back(e);
    endtask

    // Drive one operand for one edge; the caller makes sure in_ready is high
    task automatic issue(input logic [DW-1:0] a, input logic [DSW-1:0] b);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        push_exp(a, b);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    // Count edges after the accept until out_valid, with a bounded wait
    task automatic wait_valid(output int edges);
        edges = 0;
        while (out_valid !== 1'b1 && edges < 100) begin
            @(posedge clock);
            #1;
            edges++;
        end
    endtask

    function automatic int exp_latency(input logic [DSW-1:0] b);
        int lat;
        lat = (b == 4'd0) ? 0 : N;
`ifdef SMALLDIV_SEQ_POW2_BYPASS_EN
        if (b != 4'd0 && (b & (b - 4'd1)) == 4'd0) lat = 0;
`endif
        return lat;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        @(posedge clock);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++; if (quotient !== 18'd0) begin errors++; $display("FAIL reset_quotient got=%0d want=0", quotient); end
        checks++; if (remainder !== 4'd0) begin errors++; $display("FAIL reset_remainder got=%0d want=0", remainder); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got=%b want=0", div_by_zero); end
        reset = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic test_basic();
        int   ed;
        exp_t e;
        issue(18'd100, 4'd7);
        wait_valid(ed);
        checks++; if (ed != N) begin errors++; $display("FAIL basic_latency got=%0d want=%0d", ed, N); end
        e = sb.pop_front();
        checks++;
        if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.z} || e.q !== 18'd14 || e.r !== 4'd2) begin
            errors++; $display("FAIL basic_100_7 got=%0d r %0d z %b want=14 r 2 z 0", quotient, remainder, div_by_zero);
        end
        @(posedge clock);
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL basic_retire out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
        checks++; if (quotient !== 18'd14 || remainder !== 4'd2) begin errors++; $display("FAIL basic_hold_after_retire got=%0d r %0d want=14 r 2", quotient, remainder); end
    endtask

    task automatic test_max();
        int   ed;
        exp_t e;
        issue(18'd262143, 4'd15);
        wait_valid(ed);
        checks++; if (ed != N) begin errors++; $display("FAIL max_latency got=%0d want=%0d", ed, N); end
        e = sb.pop_front();
        checks++;
        if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.z} || e.q !== 18'd17476) begin
            errors++; $display("FAIL max_262143_15 got=%0d r %0d z %b want=17476 r 3 z 0", quotient, remainder, div_by_zero);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_div_zero();
        int   ed;
        exp_t e;
        issue(18'd55, 4'd0);
        wait_valid(ed);
        checks++; if (ed != 0) begin errors++; $display("FAIL dbz_latency got=%0d want=0", ed); end
        e = sb.pop_front();
        checks++;
        if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.z} || quotient !== 18'd262143) begin
            errors++; $display("FAIL dbz_55_0 got=%0d r %0d z %b want=262143 r 0 z 1", quotient, remainder, div_by_zero);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_backpressure();
        int   ed;
        exp_t e;
        out_ready = 1'b0;
        issue(18'd50, 4'd6);
        wait_valid(ed);
        e = sb.pop_front();
        checks++;
        if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.z}) begin
            errors++; $display("FAIL bp_50_6 got=%0d r %0d z %b want=%0d r %0d z %b", quotient, remainder, div_by_zero, e.q, e.r, e.z);
        end
        // The next operand waits at the input while the consumer stalls
        in_valid = 1'b1;
        dividend = 18'd40;
        divisor  = 4'd3;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock);
            #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== 18'd8 || remainder !== 4'd2 || div_by_zero !== 1'b0) begin
                errors++; $display("FAIL bp_hold cyc=%0d valid=%b ready=%b got=%0d r %0d want valid=1 ready=0 8 r 2", i, out_valid, in_ready, quotient, remainder);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got=%b want=1", in_ready); end
        push_exp(18'd40, 4'd3);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_same_edge_accept out_valid=%b want=0", out_valid); end
        wait_valid(ed);
        checks++; if (ed != N) begin errors++; $display("FAIL bp_new_latency got=%0d want=%0d", ed, N); end
        e = sb.pop_front();
        checks++;
        if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.z} || e.q !== 18'd13 || e.r !== 4'd1) begin
            errors++; $display("FAIL bp_40_3 got=%0d r %0d z %b want=13 r 1 z 0", quotient, remainder, div_by_zero);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset_midrun();
        int   ed;
        exp_t e;
        issue(18'd500, 4'd3);
        repeat (4) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || quotient !== 18'd0 || div_by_zero !== 1'b0) begin
            errors++; $display("FAIL midrun_reset out_valid=%b in_ready=%b q=%0d want 0/1/0", out_valid, in_ready, quotient);
        end
        #1;
        reset = 1'b0;
        sb.delete();
        issue(18'd9, 4'd4);
        wait_valid(ed);
        checks++; if (ed != exp_latency(4'd4)) begin errors++; $display("FAIL midrun_next_latency got=%0d want=%0d", ed, exp_latency(4'd4)); end
        e = sb.pop_front();
        checks++;
        if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.z} || e.q !== 18'd2 || e.r !== 4'd1) begin
            errors++; $display("FAIL midrun_9_4 got=%0d r %0d z %b want=2 r 1 z 0", quotient, remainder, div_by_zero);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_pow2();
        int   ed;
        exp_t e;
        issue(18'd1000, 4'd8);
        wait_valid(ed);
        checks++; if (ed != exp_latency(4'd8)) begin errors++; $display("FAIL pow2_latency got=%0d want=%0d", ed, exp_latency(4'd8)); end
        e = sb.pop_front();
        checks++;
        if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.z} || e.q !== 18'd125) begin
            errors++; $display("FAIL pow2_1000_8 got=%0d r %0d z %b want=125 r 0 z 0", quotient, remainder, div_by_zero);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0]  a_tab[6] = '{18'd77, 18'd0, 18'd13, 18'd3, 18'd262143, 18'd1000};
        logic [DSW-1:0] b_tab[6] = '{4'd5, 4'd9, 4'd0, 4'd14, 4'd1, 4'd3};
        int   ed;
        exp_t e;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            dividend = a_tab[i];
            divisor  = b_tab[i];
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready op=%0d got=%b want=1", i, in_ready); end
            push_exp(a_tab[i], b_tab[i]);
            @(posedge clock);
            #1;
            in_valid = 1'b0;
            wait_valid(ed);
            checks++; if (ed != exp_latency(b_tab[i])) begin errors++; $display("FAIL b2b_latency op=%0d got=%0d want=%0d", i, ed, exp_latency(b_tab[i])); end
            e = sb.pop_front();
            checks++;
            if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.z}) begin
                errors++; $display("FAIL b2b_result op=%0d got=%0d r %0d z %b want=%0d r %0d z %b", i, quotient, remainder, div_by_zero, e.q, e.r, e.z);
            end
        end
        @(posedge clock);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_final_retire out_valid=%b want=0", out_valid); end
    endtask

    task automatic test_sweep();
        int            ed;
        exp_t          e;
        logic [DW-1:0] a;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        @(posedge clock);
        #1;
        out_ready = 1'b1;
        for (int d = 1; d < 16; d++) begin
            for (int j = 0; j < 4; j++) begin
                if (j == 0) a = 18'd262143;
                else if (j == 1) a = DW'(d - 1);
                else a = DW'($urandom_range(0, 262143));
                issue(a, DSW'(d));
                wait_valid(ed);
                e = sb.pop_front();
                checks++;
                if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.z}) begin
                    errors++; $display("FAIL sweep_bpc1 %0d/%0d got=%0d r %0d want=%0d r %0d", a, d, quotient, remainder, e.q, e.r);
                end
                checks++;
                if ({quotient2, remainder2, dbz2} !== {e.q, e.r, e.z}) begin
                    errors++; $display("FAIL sweep_bpc2 %0d/%0d got=%0d r %0d want=%0d r %0d", a, d, quotient2, remainder2, e.q, e.r);
                end
                checks++;
                if ({quotient3, remainder3, dbz3} !== {e.q, e.r, e.z}) begin
                    errors++; $display("FAIL sweep_bpc3 %0d/%0d got=%0d r %0d want=%0d r %0d", a, d, quotient3, remainder3, e.q, e.r);
                end
            end
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        dividend  = 18'd0;
        divisor   = 4'd0;
        test_reset();
        test_basic();
        test_max();
        test_div_zero();
        test_backpressure();
        test_reset_midrun();
        test_pow2();
        test_back_to_back();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
